// File: rtl/cam_capture_pkg.sv
// Shared definitions for the camera capture path: FSM states, RGB444 byte slices and
// output frame geometry (320x240, also used by address_gen).
package cam_capture_pkg;

   typedef enum logic [1:0] {
      ST_SYNC   = 2'd0,
      ST_VBLANK = 2'd1,
      ST_HBLANK = 2'd2,
      ST_ACTIVE = 2'd3
   } cam_state_t;

   // byte0 carries R in its low nibble; byte1 carries {G,B} whole.
   localparam int RGB_W      = 12;
   localparam int B0_NIB_HI  = 3;
   localparam int B0_NIB_LO  = 0;

   localparam int FRAME_W    = 320;
   localparam int FRAME_H    = 240;

endpackage

// File: rtl/cam_capture_sync.sv
// cam_sync: STAGES-deep synchronizer for one camera pin; level, rise and fall all emerge
// aligned, STAGES cycles after the pin is sampled; no backpressure.
module cam_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic i_pin,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [STAGES-1:0] sr;

   // Edges are registered from the stage before the last, so they line up with o_level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr     <= '0;
         o_rise <= 1'b0;
         o_fall <= 1'b0;
      end else begin
         sr     <= {sr[STAGES-2:0], i_pin};
         o_rise <= sr[STAGES-2] & ~sr[STAGES-1];
         o_fall <= ~sr[STAGES-2] & sr[STAGES-1];
      end
   end

   assign o_level = sr[STAGES-1];

endmodule

// File: rtl/cam_capture.sv
// OV7670 pin capture: pairs bytes into RGB444 pixels with line/pixel coordinates; o_we follows
// a pclk rise by SYNC_STAGES+1 cycles, no backpressure. CAM_CAPTURE_DECIMATE_EN selects 2:1 decimation.
module cam_capture
   import cam_capture_pkg::*;
#(
   parameter int CAM_DATA_WIDTH = 12,
   parameter int CAM_LINE       = 9,
   parameter int CAM_PIXEL      = 10,
   parameter int SYNC_STAGES    = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_cam_pclk,
   input  logic                      i_cam_vsync,
   input  logic                      i_cam_href,
   input  logic [7:0]                i_cam_d,
   output logic                      o_we,
   output logic [CAM_DATA_WIDTH-1:0] o_data,
   output logic [CAM_LINE-1:0]       o_line,
   output logic [CAM_PIXEL-1:0]      o_pixel,
   output logic                      o_frame_done
);

`ifdef CAM_CAPTURE_DECIMATE_EN
   localparam int DEC = 1;
`else
   localparam int DEC = 0;
`endif
   localparam int LW = CAM_LINE + DEC;
   localparam int PW = CAM_PIXEL + DEC;
   localparam logic [LW-1:0] LMAX = {LW{1'b1}};
   localparam logic [PW-1:0] PMAX = {PW{1'b1}};

   logic pclk_rise, pclk_unused_lvl, pclk_unused_fall;
   logic vs_lvl, vs_rise, vs_fall;
   logic href_lvl, href_fall, href_unused_rise;
   logic [SYNC_STAGES-1:0][7:0] d_dly;
   logic [7:0] d_s;

   cam_sync #(.STAGES(SYNC_STAGES)) u_sync_pclk (
      .clk(clk), .rst(rst), .i_pin(i_cam_pclk),
      .o_level(pclk_unused_lvl), .o_rise(pclk_rise), .o_fall(pclk_unused_fall));

   cam_sync #(.STAGES(SYNC_STAGES)) u_sync_vsync (
      .clk(clk), .rst(rst), .i_pin(i_cam_vsync),
      .o_level(vs_lvl), .o_rise(vs_rise), .o_fall(vs_fall));

   cam_sync #(.STAGES(SYNC_STAGES)) u_sync_href (
      .clk(clk), .rst(rst), .i_pin(i_cam_href),
      .o_level(href_lvl), .o_rise(href_unused_rise), .o_fall(href_fall));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) d_dly <= '0;
      else     d_dly <= {d_dly[SYNC_STAGES-2:0], i_cam_d};
   end
   assign d_s = d_dly[SYNC_STAGES-1];

   cam_state_t state, state_nxt;
   logic [LW-1:0] line, line_nxt;
   logic [PW-1:0] pixel, pixel_nxt;
   logic phase, phase_nxt;
   logic px_sat, px_sat_nxt, ln_sat, ln_sat_nxt;
   logic [7:0] byte0, byte0_nxt;
   logic we_nxt, done_nxt;
   logic [CAM_DATA_WIDTH-1:0] data_nxt;
   logic [CAM_LINE-1:0] oline_nxt;
   logic [CAM_PIXEL-1:0] opix_nxt;
   logic cap, keep;

   assign cap = pclk_rise & href_lvl & ~vs_lvl;
`ifdef CAM_CAPTURE_DECIMATE_EN
   assign keep = ~pixel[0] & ~line[0];
`else
   assign keep = 1'b1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_SYNC;
         line         <= '0;
         pixel        <= '0;
         phase        <= 1'b0;
         px_sat       <= 1'b0;
         ln_sat       <= 1'b0;
         byte0        <= '0;
         o_we         <= 1'b0;
         o_frame_done <= 1'b0;
         o_data       <= '0;
         o_line       <= '0;
         o_pixel      <= '0;
      end else begin
         state        <= state_nxt;
         line         <= line_nxt;
         pixel        <= pixel_nxt;
         phase        <= phase_nxt;
         px_sat       <= px_sat_nxt;
         ln_sat       <= ln_sat_nxt;
         byte0        <= byte0_nxt;
         o_we         <= we_nxt;
         o_frame_done <= done_nxt;
         o_data       <= data_nxt;
         o_line       <= oline_nxt;
         o_pixel      <= opix_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      line_nxt   = line;
      pixel_nxt  = pixel;
      phase_nxt  = phase;
      px_sat_nxt = px_sat;
      ln_sat_nxt = ln_sat;
      byte0_nxt  = byte0;
      we_nxt     = 1'b0;
      done_nxt   = 1'b0;
      data_nxt   = o_data;
      oline_nxt  = o_line;
      opix_nxt   = o_pixel;
      case (state)
         ST_SYNC: begin
            if (vs_rise) state_nxt = ST_VBLANK;
         end
         ST_VBLANK: begin
            line_nxt   = '0;
            pixel_nxt  = '0;
            phase_nxt  = 1'b0;
            px_sat_nxt = 1'b0;
            ln_sat_nxt = 1'b0;
            if (vs_fall) state_nxt = ST_HBLANK;
         end
         ST_HBLANK: begin
            if (vs_rise) begin
               done_nxt  = 1'b1;
               state_nxt = ST_VBLANK;
            end else if (cap) begin
               byte0_nxt = d_s;
               phase_nxt = 1'b1;
               state_nxt = ST_ACTIVE;
            end
         end
         default: begin
            if (vs_rise) begin
               done_nxt  = 1'b1;
               state_nxt = ST_VBLANK;
            end else if (href_fall) begin
               // Any unpaired trailing byte is simply forgotten here.
               state_nxt  = ST_HBLANK;
               pixel_nxt  = '0;
               phase_nxt  = 1'b0;
               px_sat_nxt = 1'b0;
               if (line == LMAX) ln_sat_nxt = 1'b1;
               else              line_nxt   = line + 1'b1;
            end else if (cap) begin
               if (!phase) begin
                  byte0_nxt = d_s;
                  phase_nxt = 1'b1;
               end else begin
                  phase_nxt = 1'b0;
                  if (!px_sat && !ln_sat) begin
                     if (keep) begin
                        we_nxt    = 1'b1;
                        data_nxt  = {byte0[B0_NIB_HI:B0_NIB_LO], d_s};
                        oline_nxt = line[LW-1:DEC];
                        opix_nxt  = pixel[PW-1:DEC];
                     end
                     if (pixel == PMAX) px_sat_nxt = 1'b1;
                     else               pixel_nxt  = pixel + 1'b1;
                  end
               end
            end
         end
      endcase
   end

endmodule
